mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing one single-ported memory between the core's instruction-fetch port and its load/store port. Sits between the core and the memory model/SRAM wrapper. Serialises requests, registers the granted address/data onto the memory port, holds it until the memory acknowledges, and returns read data with a one-cycle acknowledge pulse to the owning requester.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  instruction-fetch request; held with `if_addr` until `if_ack`.
- `if_addr`  in  AW  fetch address.
- `if_rdata`  out  DW  fetched word, valid while `if_ack` is high.
- `if_ack`  out  1  one-cycle fetch-complete pulse.
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_rdata`  out  DW  load data, valid while `d_ack` is high.
- `d_ack`  out  1  one-cycle data-complete pulse.
- `m_req`  out  1  memory request; held until `m_ack` is sampled.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  AW  memory address, registered.
- `m_wdata`  out  DW  memory write data, registered.
- `m_rdata`  in  DW  memory read data, sampled with `m_ack`.
- `m_ack`  in  1  memory completion; may be high in the first `m_req` cycle (zero wait).
- `owner`  out  1  0 = fetch, 1 = data; current/last grant.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if neither request, stay. Otherwise select a winner (see arbitration), register its address/we/wdata to `m_*`, set `m_req`=1, `owner`=winner, go BUSY.
- BUSY: hold all `m_*` stable. On edge where `m_ack`=1: `m_req`←0, winner's rdata register ← `m_rdata` (loads/fetches only; stores leave `d_rdata` unchanged), winner's ack ← 1, go RESP.
- RESP: ack high exactly this cycle; no new grant taken; next edge ack←0, go IDLE.
- Requests high in IDLE are always treated as new requests; back-to-back requests by one requester are legal.
- Arbitration without macro: data wins when both request; fetch can be starved by continuous data traffic (core never does this).
- Store on fetch port impossible: `m_we` forced 0 for fetch grants.
- Addresses and data pass unmodified; no alignment check.
- Requests changing address while pending: ignored; registered values are used.
- Reset (any time, including mid-BUSY): state→IDLE; `m_req`, `m_we`, `if_ack`, `d_ack`, `owner` → 0; `m_addr`, `m_wdata`, `if_rdata`, `d_rdata` → 0. An in-flight memory transaction is abandoned; a late `m_ack` arriving in IDLE is ignored.

## Timing
- Request seen in IDLE at edge E0 → `m_req` high from E0.
- Zero-wait memory (`m_ack` high first BUSY cycle): ack pulse in cycle after E1; request-to-ack = 2 cycles; throughput 1 transaction per 3 cycles.
- Memory wait states W add W cycles.
- All outputs registered; no combinational path input→output.

## Configuration
- `MEM_ARBITER_RR_EN` defined: round-robin. 1-bit last-grant pointer, reset = fetch (so data wins first contention). On contention, grant the requester not granted last; pointer updates on every grant. Uncontended requests granted immediately regardless of pointer.
- Undefined: fixed data priority, no pointer.

## Test plan
- Reset: `rst_n`=0 with both reqs high → all outputs 0, no `m_req`; release → data granted first.
- Single fetch, zero-wait: `if_addr`=0x100, `m_rdata`=0xDEADBEEF → `m_req` 1 cycle, `if_ack` pulse 2 cycles after req with `if_rdata`=0xDEADBEEF, `d_ack` never.
- Store with 3 wait states: `d_we`=1, `d_addr`=0x200, `d_wdata`=0x12345678 → `m_we`=1, `m_addr`/`m_wdata` stable 4 cycles, `d_ack` after, `d_rdata` unchanged.
- Contention, both held for 4 transactions: without macro → data,data,data,data; with `MEM_ARBITER_RR_EN` → data,fetch,data,fetch.
- Reset mid-BUSY then stray `m_ack` in IDLE → no ack pulse, `m_req` stays 0.
- Address changed during BUSY (0x100→0x104) → `m_addr` stays 0x100 until RESP.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (fetch, data) onto one single-ported memory.
// Optional MEM_ARBITER_RR_EN selects round-robin; default build gives data fixed priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_n;
    logic   grant;
    logic   grant_d;
    logic   done;

`ifdef MEM_ARBITER_RR_EN
    // 1 = data port was granted last; reset to fetch so data wins first
    logic last_d;

    // Round-robin pointer follows every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (grant) begin
            last_d <= grant_d;
        end
    end
`endif

    // Next-state and winner selection; m_ack is only looked at in BUSY
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant   = 1'b1;
                    state_n = BUSY;
`ifdef MEM_ARBITER_RR_EN
                    if (if_req && d_req) begin
                        grant_d = ~last_d;
                    end else begin
                        grant_d = d_req;
                    end
`else
                    grant_d = d_req;
`endif
                end
            end
            BUSY: begin
                if (m_ack) begin
                    done    = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Memory port, ownership and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            owner    <= 1'b0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (grant) begin
                m_req   <= 1'b1;
                owner   <= grant_d;
                m_we    <= grant_d & d_we;
                m_addr  <= grant_d ? d_addr : if_addr;
                m_wdata <= grant_d ? d_wdata : '0;
            end
            if (done) begin
                m_req <= 1'b0;
                if (owner) begin
                    d_ack <= 1'b1;
                    if (!m_we) begin
                        d_rdata <= m_rdata;
                    end
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= m_rdata;
                end
            end
            if (state == RESP) begin
                if_ack <= 1'b0;
                d_ack  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written corner sequences.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        owner;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .owner    (owner)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          waits;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[6];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic wait_mreq(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, m_req}, 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        @(negedge clk);
        d_we = v.we;
        if (v.is_d) begin
            d_req   = 1'b1;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        @(negedge clk);
        chk({s, " m_req"}, {31'd0, m_req}, 32'd1);
        chk({s, " owner"}, {31'd0, owner}, {31'd0, v.is_d});
        chk({s, " m_we"}, {31'd0, m_we}, {31'd0, v.is_d & v.we});
        chk({s, " m_addr"}, m_addr, v.addr);
        if (v.is_d && v.we) begin
            chk({s, " m_wdata"}, m_wdata, v.wdata);
        end
        for (int i = 0; i < v.waits; i++) begin
            @(negedge clk);
            chk({s, " hold m_req"}, {31'd0, m_req}, 32'd1);
            chk({s, " hold m_addr"}, m_addr, v.addr);
            chk({s, " early ack"}, {30'd0, if_ack, d_ack}, 32'd0);
        end
        m_ack   = 1'b1;
        m_rdata = v.mrdata;
        @(negedge clk);
        chk({s, " acks"}, {30'd0, if_ack, d_ack},
            v.is_d ? 32'd1 : 32'd2);
        chk({s, " m_req low"}, {31'd0, m_req}, 32'd0);
        chk({s, " rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        m_ack   = 1'b0;
        m_rdata = 32'h5555_AAAA;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        @(negedge clk);
        chk({s, " ack drop"}, {30'd0, if_ack, d_ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_own;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'hAAAA_5555, 3, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D};
        vt[3] = '{1'b1, 1'b1, 32'h0000_0304, 32'h0BAD_F00D, 32'h1111_1111, 0, 32'hCAFE_F00D};
        vt[4] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'h0123_4567, 2, 32'h0123_4567};
        vt[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF};

        rst_n   = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        if_addr = 32'h0000_0040;
        d_addr  = 32'h0000_0080;
        d_we    = 1'b0;
        d_wdata = 32'h0;
        m_rdata = 32'h0;
        m_ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst m_req", {31'd0, m_req}, 32'd0);
        chk("rst acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst owner_we", {30'd0, owner, m_we}, 32'd0);
        chk("rst m_addr", m_addr, 32'd0);
        chk("rst m_wdata", m_wdata, 32'd0);
        chk("rst rdata", if_rdata | d_rdata, 32'd0);

        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_mreq($sformatf("cont%0d m_req", k));
`ifdef MEM_ARBITER_RR_EN
            exp_own = (k % 2 == 0) ? 32'd1 : 32'd0;
`else
            exp_own = 32'd1;
`endif
            chk($sformatf("cont%0d owner", k), {31'd0, owner}, exp_own);
            m_ack   = 1'b1;
            m_rdata = 32'h0000_1000 + k;
            @(negedge clk);
            chk($sformatf("cont%0d ack", k), {30'd0, if_ack, d_ack},
                exp_own == 32'd1 ? 32'd1 : 32'd2);
            m_ack = 1'b0;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);

        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        @(negedge clk);
        chk("mid m_req", {31'd0, m_req}, 32'd1);
        rst_n  = 1'b0;
        if_req = 1'b0;
        #1;
        chk("mid rst m_req", {31'd0, m_req}, 32'd0);
        chk("mid rst rdata", if_rdata | d_rdata, 32'd0);
        chk("mid rst owner", {31'd0, owner}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ack   = 1'b1;
        m_rdata = 32'h5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray m_req", {31'd0, m_req}, 32'd0);
            chk("stray acks", {30'd0, if_ack, d_ack}, 32'd0);
        end
        m_ack = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(vt[i], i);
        end

        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        @(negedge clk);
        chk("chg m_addr", m_addr, 32'h0000_0100);
        if_addr = 32'h0000_0104;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("chg hold m_addr", m_addr, 32'h0000_0100);
        end
        m_ack   = 1'b1;
        m_rdata = 32'h0000_600D;
        @(negedge clk);
        chk("chg if_ack", {31'd0, if_ack}, 32'd1);
        chk("chg resp m_addr", m_addr, 32'h0000_0100);
        chk("chg if_rdata", if_rdata, 32'h0000_600D);
        m_ack  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk("chg ack drop", {31'd0, if_ack}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
